// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with binary wrap-bit pointers, fill level, almost flags and sticky over/underflow flags.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through read data; default is one-cycle registered read.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    winc,
    input  logic                    rinc,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    wfull,
    output logic                    rempty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    ovf_err,
    output logic                    udf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags come only from registered pointers, so no path from winc/rinc.
    assign rempty = (wptr == rptr);
    assign wfull  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    assign wr_ok = winc && !wfull;
    assign rd_ok = rinc && !rempty;

    assign almost_full  = (fill_level >= AF_L);
    assign almost_empty = (fill_level <= AE_L);

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr       <= '0;
            rptr       <= '0;
            fill_level <= '0;
            ovf_err    <= 1'b0;
            udf_err    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   fill_level <= fill_level + ONE;
                2'b01:   fill_level <= fill_level - ONE;
                default: fill_level <= fill_level;
            endcase
            if (winc && wfull) begin
                ovf_err <= 1'b1;
            end
            if (rinc && rempty) begin
                udf_err <= 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is presented directly; value is meaningless while empty.
    assign rdata = mem[rptr[AW-1:0]];
`else
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdata <= '0;
        end else if (rd_ok) begin
            rdata <= mem[rptr[AW-1:0]];
        end
    end
`endif

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, >= 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-008 SHALL have port winc  input  1  write request.
REQ-009 SHALL have port rinc  input  1  read request.
REQ-010 SHALL have port rdata  output  DATA_WIDTH  read data.
REQ-011 SHALL have port wfull  output  1  FIFO holds DEPTH entries.
REQ-012 SHALL have port rempty  output  1  FIFO holds 0 entries.
REQ-013 SHALL have port almost_full  output  1  occupancy >= AF_LEVEL.
REQ-014 SHALL have port almost_empty  output  1  occupancy <= AE_LEVEL.
REQ-015 SHALL have port fill_level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 SHALL have port ovf_err  output  1  sticky: write attempted while full.
REQ-017 SHALL have port udf_err  output  1  sticky: read attempted while empty.

Function
REQ-018 SHALL accept a write on a rising CLK edge when winc=1 and wfull=0, storing wdata at the write pointer, then incrementing the pointer.
REQ-019 SHALL accept a read on a rising CLK edge when rinc=1 and rempty=0, then increment the read pointer.
REQ-020 SHALL use log2(DEPTH)+1-bit binary pointers; wrap from DEPTH-1 to 0 on the address bits, toggling the MSB.
REQ-021 SHALL derive rempty when pointers are equal and wfull when address bits match and MSBs differ; both registered-state derived, no combinational path from winc/rinc.
REQ-022 SHALL update fill_level: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-023 SHALL, when full with winc=1 and rinc=1, accept the read and reject the write (fill_level DEPTH-1 next cycle) and set ovf_err.
REQ-024 SHALL, when empty with winc=1 and rinc=1, accept the write and reject the read (fill_level 1 next cycle) and set udf_err.
REQ-025 SHALL keep ovf_err/udf_err set until reset; rejected requests SHALL NOT modify pointers, memory or fill_level.
REQ-026 SHALL compute almost_full and almost_empty combinationally from fill_level.
REQ-027 SHALL, without the configuration feature, register rdata: on an accepted read at edge N, rdata shows the popped word after edge N and holds it until the next accepted read.

Reset
REQ-028 SHALL, on RST=0, immediately clear both pointers, fill_level, ovf_err, udf_err and rdata to 0, giving rempty=1, wfull=0, almost_empty=1, almost_full=0.
REQ-029 SHALL discard all contents on reset mid-operation; memory array SHALL NOT be reset.
REQ-030 SHALL ignore winc/rinc while RST=0; first accepted write is on the first rising edge after RST deasserts.

Configuration
REQ-031 SHALL, with macro FIFO_FWFT_EN defined, operate first-word-fall-through: rdata combinationally equals the head entry whenever rempty=0, and an accepted read advances to the next entry; rdata is don't-care when empty.
REQ-032 SHALL, without FIFO_FWFT_EN, behave per REQ-027 with one-cycle read latency.

Verification
REQ-033 SHALL cover: reset, write 0x11..0x88 (DEPTH=8) -> wfull=1 after 8th edge, fill_level=8, almost_full=1 from level 6.
REQ-034 SHALL cover: from full, 9th write 0x99 -> rejected, ovf_err=1, contents unchanged; read all -> 0x11..0x88 in order, rempty=1.
REQ-035 SHALL cover: empty, winc=1 and rinc=1 with 0xA5 -> fill_level=1, udf_err=1; next read returns 0xA5.
REQ-036 SHALL cover: level 4, simultaneous read/write for 20 cycles -> fill_level stays 4, pointer wrap, data order preserved.
REQ-037 SHALL cover: assert RST=0 mid-stream at level 5 -> all outputs to reset values without a clock edge; FIFO empty afterwards.
REQ-038 SHALL cover: both builds (with/without FIFO_FWFT_EN), write 0x3C into empty -> FWFT: rdata=0x3C before any read; non-FWFT: rdata=0x3C only after the read edge.
